alu_operand_stage: RTL and testbench

//  Issue stage directly upstream of the ALU: holds the 31x32 register file, reads rs1/rs2, selects
//  ALU A/B operands (reg/PC/imm), registers them with ALUop, rd and rd_we into one output slot.
//  A per-register pending scoreboard stalls RAW/WAW hazards until the downstream writeback retires.

---
 rtl/alu_operand_stage_if.sv | 60 ++++++
 rtl/alu_operand_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_operand_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage_if
//  Purpose  : Bundles the decode-side request, ALU-side slot, writeback port
//             and flush control of the ALU operand stage.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  // Decode side (upstream)
  logic            in_valid;
  logic            in_ready;
  logic [RAW-1:0]  in_rs1;
  logic [RAW-1:0]  in_rs2;
  logic [1:0]      in_a_sel;
  logic            in_b_sel;
  logic            in_store;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [3:0]      in_aluop;
  logic [RAW-1:0]  in_rd;
  logic            in_rd_we;

  // ALU side (downstream)
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_aluop;
  logic [XLEN-1:0] out_rs2d;
  logic [RAW-1:0]  out_rd;
  logic            out_rd_we;

  // Writeback and pipeline control
  logic            wb_en;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  // Driver of instructions, writebacks and ALU-side ready
  modport master (
    output in_valid, in_rs1, in_rs2, in_a_sel, in_b_sel, in_store,
           in_pc, in_imm, in_aluop, in_rd, in_rd_we,
           out_ready, wb_en, wb_addr, wb_data, flush,
    input  in_ready, out_valid, out_a, out_b, out_aluop, out_rs2d,
           out_rd, out_rd_we
  );

  // The operand stage itself
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_a_sel, in_b_sel, in_store,
           in_pc, in_imm, in_aluop, in_rd, in_rd_we,
           out_ready, wb_en, wb_addr, wb_data, flush,
    output in_ready, out_valid, out_a, out_b, out_aluop, out_rs2d,
           out_rd, out_rd_we
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : Issue stage ahead of the ALU. Holds the x1..x31 register file,
//             reads rs1/rs2 with writeback bypass, selects operands A/B,
//             and registers them into a single output slot. A one-bit-per-
//             register pending scoreboard stalls RAW/WAW hazards until the
//             writeback for that register retires.
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = 5
) (
  input  wire logic           clk,
  input  wire logic           resetn,
  alu_operand_stage_if.slave  i_bus
);

  // Architectural state: x0 is not stored, it reads as zero
  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic [NREG-1:0] r_pending;

  // Output slot
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_a;
  logic [XLEN-1:0] r_out_b;
  logic [3:0]      r_out_aluop;
  logic [XLEN-1:0] r_out_rs2d;
  logic [RAW-1:0]  r_out_rd;
  logic            r_out_rd_we;

  // Combinational
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_use1;
  logic            w_use2;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic            w_wb_hitd;
  logic            w_hazard;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_wb_write;
  logic            w_flush_drop;
  logic [NREG-1:0] w_pending_nxt;

  // Writebacks to x0 are architecturally discarded
  assign w_wb_write = i_bus.wb_en && (i_bus.wb_addr != '0);

  // Source reads: x0 is zero, a same-cycle writeback is bypassed in
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (i_bus.in_rs1 != '0) begin
      if (i_bus.wb_en && (i_bus.wb_addr == i_bus.in_rs1))
        w_rs1_data = i_bus.wb_data;
      else
        w_rs1_data = r_regs[i_bus.in_rs1];
    end
    if (i_bus.in_rs2 != '0) begin
      if (i_bus.wb_en && (i_bus.wb_addr == i_bus.in_rs2))
        w_rs2_data = i_bus.wb_data;
      else
        w_rs2_data = r_regs[i_bus.in_rs2];
    end
  end

  // Operand muxes: A from rs1/pc/zero, B from rs2/imm
  always_comb begin
    w_a = '0;
    case (i_bus.in_a_sel)
      2'b00:   w_a = w_rs1_data;
      2'b01:   w_a = i_bus.in_pc;
      default: w_a = '0;
    endcase
    w_b = i_bus.in_b_sel ? i_bus.in_imm : w_rs2_data;
  end

  // Hazard detection; a writeback retiring this cycle resolves the hazard
  always_comb begin
    w_use1    = (i_bus.in_a_sel == 2'b00);
    w_use2    = !i_bus.in_b_sel || i_bus.in_store;
    w_wb_hit1 = i_bus.wb_en && (i_bus.wb_addr == i_bus.in_rs1);
    w_wb_hit2 = i_bus.wb_en && (i_bus.wb_addr == i_bus.in_rs2);
    w_wb_hitd = i_bus.wb_en && (i_bus.wb_addr == i_bus.in_rd);
    w_hazard  = i_bus.in_valid && (
                  (w_use1 && r_pending[i_bus.in_rs1] && !w_wb_hit1) ||
                  (w_use2 && r_pending[i_bus.in_rs2] && !w_wb_hit2) ||
                  (i_bus.in_rd_we && (i_bus.in_rd != '0) &&
                   r_pending[i_bus.in_rd] && !w_wb_hitd));
  end

  assign w_in_ready = !i_bus.flush && !w_hazard && (!r_out_valid || i_bus.out_ready);
  assign w_accept   = i_bus.in_valid && w_in_ready;

  // A held instruction is discarded by flush only if the ALU is not taking
  // it this cycle; one that is consumed keeps its scoreboard entry.
  assign w_flush_drop = i_bus.flush && r_out_valid && !i_bus.out_ready;

  // Scoreboard next state: clears first, a new issue's set wins last
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_bus.wb_en)
      w_pending_nxt[i_bus.wb_addr] = 1'b0;
    if (w_flush_drop && r_out_rd_we)
      w_pending_nxt[r_out_rd] = 1'b0;
    if (w_accept && i_bus.in_rd_we)
      w_pending_nxt[i_bus.in_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Register file and scoreboard update
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 1; i < NREG; i++)
        r_regs[i] <= '0;
      r_pending <= '0;
    end else begin
      if (w_wb_write)
        r_regs[i_bus.wb_addr] <= i_bus.wb_data;
      r_pending <= w_pending_nxt;
    end
  end

  // Output slot: load on accept, empty on flush or on consume-only
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_aluop <= '0;
      r_out_rs2d  <= '0;
      r_out_rd    <= '0;
      r_out_rd_we <= 1'b0;
    end else if (i_bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_a;
      r_out_b     <= w_b;
      r_out_aluop <= i_bus.in_aluop;
      r_out_rs2d  <= w_rs2_data;
      r_out_rd    <= i_bus.in_rd;
      r_out_rd_we <= i_bus.in_rd_we;
    end else if (i_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign i_bus.in_ready  = w_in_ready;
  assign i_bus.out_valid = r_out_valid;
  assign i_bus.out_a     = r_out_a;
  assign i_bus.out_b     = r_out_b;
  assign i_bus.out_aluop = r_out_aluop;
  assign i_bus.out_rs2d  = r_out_rs2d;
  assign i_bus.out_rd    = r_out_rd;
  assign i_bus.out_rd_we = r_out_rd_we;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Directed, table-driven bench for alu_operand_stage with
//             hand-written hazard, backpressure and flush sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  alu_operand_stage_if #(.XLEN(32), .RAW(5)) bus ();

  alu_operand_stage #(.XLEN(32), .NREG(32), .RAW(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .i_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic        store;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ers2;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [1:0] a_sel, input logic b_sel,
                           input logic store, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [3:0] aluop,
                           input logic [4:0] rd, input logic rd_we);
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_a_sel = a_sel;
    bus.in_b_sel = b_sel;
    bus.in_store = store;
    bus.in_pc    = pc;
    bus.in_imm   = imm;
    bus.in_aluop = aluop;
    bus.in_rd    = rd;
    bus.in_rd_we = rd_we;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  // Watchdog: the directed sequence is short; a stall here means a broken run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            wb  wba wbdata        rs1 rs2 asel b st  pc            imm           op    rd  we  A             B             rs2d
    tbl[0] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h4,        4'h2, 5'd0, 1'b0, 32'h0000_1234, 32'h4,        32'h0};
    tbl[1] = '{1'b1, 5'd6, 32'hDEAD_BEEF, 5'd1, 5'd6, 2'b00, 1'b0, 1'b0, 32'h0,     32'h0,        4'h1, 5'd0, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd2, 2'b01, 1'b0, 1'b0, 32'h1000,   32'h0,        4'h3, 5'd0, 1'b0, 32'h0000_1000, 32'h2222_2222, 32'h2222_2222};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd31, 2'b10, 1'b1, 1'b1, 32'h0,     32'hFFFF_FFF0, 4'h4, 5'd0, 1'b0, 32'h0,        32'hFFFF_FFF0, 32'hFFFF_FFFF};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd0, 2'b11, 1'b0, 1'b0, 32'h55,     32'h0,        4'h5, 5'd0, 1'b0, 32'h0,         32'h0,         32'h0};
    tbl[5] = '{1'b1, 5'd0, 32'h5,        5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0,      32'h0,        4'h6, 5'd0, 1'b1, 32'h0,         32'h0,         32'h0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd31, 5'd3, 2'b00, 1'b0, 1'b0, 32'h0,     32'h0,        4'hF, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    tbl[7] = '{1'b1, 5'd1, 32'hCAFE_F00D, 5'd1, 5'd1, 2'b00, 1'b0, 1'b0, 32'h0,     32'h0,        4'h7, 5'd0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
    tbl[8] = '{1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 2'b00, 1'b1, 1'b1, 32'h0,      32'h7,        4'h8, 5'd0, 1'b0, 32'hCAFE_F00D, 32'h7,        32'h0};

    // Reset held two cycles while an instruction is offered
    resetn        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    set_instr(5'd1, 5'd2, 2'b01, 1'b1, 1'b1, 32'hAAAA_0000, 32'h1234, 4'hA, 5'd3, 1'b1);
    tick();
    tick();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_a",     bus.out_a, 32'h0);
    chk("rst_out_b",     bus.out_b, 32'h0);
    chk("rst_out_rs2d",  bus.out_rs2d, 32'h0);
    chk("rst_out_misc",  {22'b0, bus.out_aluop, bus.out_rd, bus.out_rd_we}, 32'h0);
    bus.in_valid = 1'b0;
    resetn       = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("rst_idle_valid", {31'b0, bus.out_valid}, 32'h0);

    // Preload register file through the writeback port
    wb(5'd1,  32'h1111_1111);
    wb(5'd2,  32'h2222_2222);
    wb(5'd3,  32'h8000_0000);
    wb(5'd31, 32'hFFFF_FFFF);
    wb(5'd5,  32'h0000_1234);
    wb(5'd8,  32'h0000_8888);

    // Table: back-to-back issue with the ALU always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.wb_en   = tbl[i].wb_en;
      bus.wb_addr = tbl[i].wb_addr;
      bus.wb_data = tbl[i].wb_data;
      set_instr(tbl[i].rs1, tbl[i].rs2, tbl[i].a_sel, tbl[i].b_sel, tbl[i].store,
                tbl[i].pc, tbl[i].imm, tbl[i].aluop, tbl[i].rd, tbl[i].rd_we);
      bus.in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, 32'h1);
      tick();
      bus.wb_en = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, 32'h1);
      chk($sformatf("v%0d_a", i),     bus.out_a, tbl[i].ea);
      chk($sformatf("v%0d_b", i),     bus.out_b, tbl[i].eb);
      chk($sformatf("v%0d_rs2d", i),  bus.out_rs2d, tbl[i].ers2);
      chk($sformatf("v%0d_misc", i),  {22'b0, bus.out_aluop, bus.out_rd, bus.out_rd_we},
          {22'b0, tbl[i].aluop, tbl[i].rd, tbl[i].rd_we});
    end
    bus.in_valid = 1'b0;
    tick();
    chk("consume_empties", {31'b0, bus.out_valid}, 32'h0);

    // RAW: consumer of x7 waits for its writeback, accepted in the wb cycle
    set_instr(5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd7, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    chk("raw_prod_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    set_instr(5'd7, 5'd0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1, 4'h0, 5'd0, 1'b0);
    #1;
    chk("raw_stall", {31'b0, bus.in_ready}, 32'h0);
    tick();
    tick();
    chk("raw_stall_hold", {31'b0, bus.in_ready}, 32'h0);
    chk("raw_slot_empty", {31'b0, bus.out_valid}, 32'h0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd7;
    bus.wb_data = 32'h9;
    #1;
    chk("raw_release", {31'b0, bus.in_ready}, 32'h1);
    tick();
    bus.wb_en = 1'b0;
    chk("raw_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("raw_a", bus.out_a, 32'h9);

    // WAW stall, then issue-set wins over same-cycle writeback clear
    set_instr(5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd9, 1'b1);
    #1;
    tick();
    #1;
    chk("waw_stall", {31'b0, bus.in_ready}, 32'h0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd9;
    bus.wb_data = 32'h1;
    #1;
    chk("waw_release", {31'b0, bus.in_ready}, 32'h1);
    tick();
    bus.wb_en = 1'b0;
    set_instr(5'd9, 5'd0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);
    #1;
    chk("set_wins_over_wb", {31'b0, bus.in_ready}, 32'h0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd9;
    bus.wb_data = 32'h99;
    #1;
    chk("x9_release", {31'b0, bus.in_ready}, 32'h1);
    tick();
    bus.wb_en = 1'b0;
    chk("x9_a", bus.out_a, 32'h99);
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: wb to x0 ignored, rd=0 sets no pending, slot holds steady
    bus.out_ready = 1'b0;
    bus.wb_en     = 1'b1;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'h5;
    set_instr(5'd0, 5'd2, 2'b00, 1'b1, 1'b1, 32'h0, 32'h55, 4'h3, 5'd0, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    chk("bp_accept_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    bus.wb_en = 1'b0;
    set_instr(5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 32'h0, 32'hAA, 4'h4, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_in_ready", c), {31'b0, bus.in_ready}, 32'h0);
      chk($sformatf("bp%0d_valid", c), {31'b0, bus.out_valid}, 32'h1);
      chk($sformatf("bp%0d_a", c), bus.out_a, 32'h0);
      chk($sformatf("bp%0d_b", c), bus.out_b, 32'h55);
      chk($sformatf("bp%0d_rs2d", c), bus.out_rs2d, 32'h2222_2222);
      chk($sformatf("bp%0d_misc", c), {22'b0, bus.out_aluop, bus.out_rd, bus.out_rd_we},
          {22'b0, 4'h3, 5'd0, 1'b1});
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_x0_no_pending", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("bp_next_b", bus.out_b, 32'hAA);
    chk("bp_next_op", {28'b0, bus.out_aluop}, 32'h4);
    bus.in_valid = 1'b0;
    tick();

    // Flush: held rd=8 writer discarded, its scoreboard entry released
    bus.out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 2'b10, 1'b1, 1'b0, 32'h0, 32'h88, 4'h1, 5'd8, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    tick();
    chk("fl_held", {31'b0, bus.out_valid}, 32'h1);
    set_instr(5'd8, 5'd0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 4'h2, 5'd0, 1'b0);
    #1;
    chk("fl_pre_stall", {31'b0, bus.in_ready}, 32'h0);
    bus.flush = 1'b1;
    #1;
    chk("fl_blocks_accept", {31'b0, bus.in_ready}, 32'h0);
    tick();
    bus.flush = 1'b0;
    chk("fl_clears_valid", {31'b0, bus.out_valid}, 32'h0);
    #1;
    chk("fl_ready_after", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("fl_next_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("fl_next_a", bus.out_a, 32'h0000_8888);
    bus.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
